// File: rtl/rob_ctrl_pkg.sv
// Shared configuration for the reorder-buffer controller: sizes, widths and
// the encoding used to classify a committed branch as hit or mispredict.
package rob_ctrl_pkg;

    localparam int ROB_SIZE = 15;
    localparam int NICK_W   = 4;
    localparam int NAME_W   = 5;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;

    typedef enum logic {
        PRED_HIT  = 1'b0,
        PRED_MISS = 1'b1
    } pred_e;

    function automatic pred_e predOutcome(input logic predTaken, input logic actualTaken);
        return (predTaken != actualTaken) ? PRED_MISS : PRED_HIT;
    endfunction

endpackage

// File: rtl/rob_ctrl.sv
// Reorder buffer controller: allocates tags at dispatch, captures CDB results,
// answers operand-tag lookups and retires the head in order, flushing the
// whole buffer when a committed branch turns out to be mispredicted.
module rob_ctrl
    import rob_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              iDP_en,
    input  logic [NAME_W-1:0] iDP_rd_regnm,
    input  logic              iDP_st,
    input  logic              iDP_br,
    input  logic              iDP_pd,
    input  logic [NICK_W-1:0] iDP_q1_nick,
    input  logic [NICK_W-1:0] iDP_q2_nick,
    output logic              oDP_full,
    output logic [NICK_W-1:0] oDP_nick,
    output logic              oDP_q1_rdy,
    output logic              oDP_q2_rdy,
    output logic [DATA_W-1:0] oDP_q1_dt,
    output logic [DATA_W-1:0] oDP_q2_dt,
    output logic              oRF_nick_en,
    output logic [NAME_W-1:0] oRF_nick_regnm,
    output logic [NICK_W-1:0] oRF_nick,
    input  logic              iCDB_en,
    input  logic [NICK_W-1:0] iCDB_nick,
    input  logic [DATA_W-1:0] iCDB_dt,
    input  logic              iCDB_jump,
    input  logic [ADDR_W-1:0] iCDB_tgt,
    output logic              oRF_en,
    output logic [NAME_W-1:0] oRF_rd_regnm,
    output logic [DATA_W-1:0] oRF_rd_dt,
    output logic [NICK_W-1:0] oRF_rd_nick,
    output logic              oLSB_commit,
    output logic [NICK_W-1:0] oLSB_nick,
    output logic              oCLR,
    output logic [ADDR_W-1:0] oIF_pc
);

    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int CNT_W = $clog2(ROB_SIZE + 1);

    logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [ROB_SIZE-1:0] valid_q, ready_q, st_q, br_q, pd_q, jump_q;
    logic [NAME_W-1:0]   rd_q  [ROB_SIZE];
    logic [DATA_W-1:0]   dt_q  [ROB_SIZE];
    logic [ADDR_W-1:0]   tgt_q [ROB_SIZE];

    logic                alloc, commitFire, mispredict, cdbHit;
    logic [IDX_W-1:0]    cdbIdx;
    logic [NICK_W-1:0]   headNick;
    logic [DATA_W:0]     q1Look, q2Look;

    function automatic logic [IDX_W-1:0] incIdx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(ROB_SIZE - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // A CDB hit on the tag being looked up wins over stored data, so a
    // consumer dispatched in the broadcast cycle never misses the value.
    function automatic logic [DATA_W:0] lookupTag(input logic [NICK_W-1:0] tag);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(tag - NICK_W'(1));
        if (tag == '0) return '0;
        if (iCDB_en && (iCDB_nick == tag)) return {1'b1, iCDB_dt};
        if (valid_q[idx] && ready_q[idx]) return {1'b1, dt_q[idx]};
        return '0;
    endfunction

    // Dispatch, writeback and commit qualifiers plus all combinational outputs.
    always_comb begin
        oDP_full       = (count_q == CNT_W'(ROB_SIZE));
        oDP_nick       = NICK_W'(tail_q) + NICK_W'(1);
        headNick       = NICK_W'(head_q) + NICK_W'(1);
        alloc          = rdy && iDP_en && !oDP_full && !oCLR;
        oRF_nick_en    = alloc && !iDP_st && (iDP_rd_regnm != '0);
        oRF_nick       = oDP_nick;
        oRF_nick_regnm = iDP_rd_regnm;
        cdbIdx         = IDX_W'(iCDB_nick - NICK_W'(1));
        cdbHit         = iCDB_en && (iCDB_nick != '0) && valid_q[cdbIdx];
        commitFire     = rdy && valid_q[head_q] && ready_q[head_q];
        mispredict     = commitFire && br_q[head_q] &&
                         (predOutcome(pd_q[head_q], jump_q[head_q]) == PRED_MISS);
        q1Look         = lookupTag(iDP_q1_nick);
        q2Look         = lookupTag(iDP_q2_nick);
        oDP_q1_rdy     = q1Look[DATA_W];
        oDP_q1_dt      = q1Look[DATA_W-1:0];
        oDP_q2_rdy     = q2Look[DATA_W];
        oDP_q2_dt      = q2Look[DATA_W-1:0];
    end

    // Next head/tail/count; a mispredict empties the buffer outright.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy) begin
            if (mispredict) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (commitFire) head_d = incIdx(head_q);
                if (alloc)      tail_d = incIdx(tail_q);
                count_d = count_q + CNT_W'(alloc) - CNT_W'(commitFire);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: writeback, allocation and retirement of the head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ready_q <= '0;
            st_q    <= '0;
            br_q    <= '0;
            pd_q    <= '0;
            jump_q  <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_q[i]  <= '0;
                dt_q[i]  <= '0;
                tgt_q[i] <= '0;
            end
        end else if (rdy) begin
            if (mispredict) begin
                valid_q <= '0;
                ready_q <= '0;
            end else begin
                if (cdbHit) begin
                    ready_q[cdbIdx] <= 1'b1;
                    dt_q[cdbIdx]    <= iCDB_dt;
                    jump_q[cdbIdx]  <= iCDB_jump;
                    tgt_q[cdbIdx]   <= iCDB_tgt;
                end
                if (commitFire) valid_q[head_q] <= 1'b0;
                if (alloc) begin
                    valid_q[tail_q] <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    rd_q[tail_q]    <= iDP_rd_regnm;
                    st_q[tail_q]    <= iDP_st;
                    br_q[tail_q]    <= iDP_br;
                    pd_q[tail_q]    <= iDP_pd;
                end
            end
        end
    end

    // Registered commit outputs; pulses drop whenever no commit happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oRF_en       <= 1'b0;
            oRF_rd_regnm <= '0;
            oRF_rd_dt    <= '0;
            oRF_rd_nick  <= '0;
            oLSB_commit  <= 1'b0;
            oLSB_nick    <= '0;
            oCLR         <= 1'b0;
            oIF_pc       <= '0;
        end else if (!rdy) begin
            oRF_en      <= 1'b0;
            oLSB_commit <= 1'b0;
            oCLR        <= 1'b0;
        end else begin
            oRF_en      <= commitFire && !st_q[head_q] && !br_q[head_q] && (rd_q[head_q] != '0);
            oLSB_commit <= commitFire && st_q[head_q];
            oCLR        <= mispredict;
            if (commitFire) begin
                oRF_rd_regnm <= rd_q[head_q];
                oRF_rd_dt    <= dt_q[head_q];
                oRF_rd_nick  <= headNick;
                oLSB_nick    <= headNick;
            end
            if (mispredict) oIF_pc <= tgt_q[head_q];
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: a queue-based reference model of the reorder buffer is
// compared against the DUT on every falling edge, with directed scenarios
// pinned by literal expectations followed by randomized traffic.
module tb_rob_ctrl;
    import rob_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n, rdy;
    logic              iDP_en, iDP_st, iDP_br, iDP_pd;
    logic [NAME_W-1:0] iDP_rd_regnm;
    logic [NICK_W-1:0] iDP_q1_nick, iDP_q2_nick;
    logic              oDP_full, oDP_q1_rdy, oDP_q2_rdy, oRF_nick_en;
    logic [NICK_W-1:0] oDP_nick, oRF_nick, oRF_rd_nick, oLSB_nick;
    logic [DATA_W-1:0] oDP_q1_dt, oDP_q2_dt, oRF_rd_dt;
    logic [NAME_W-1:0] oRF_nick_regnm, oRF_rd_regnm;
    logic              iCDB_en, iCDB_jump;
    logic [NICK_W-1:0] iCDB_nick;
    logic [DATA_W-1:0] iCDB_dt;
    logic [ADDR_W-1:0] iCDB_tgt, oIF_pc;
    logic              oRF_en, oLSB_commit, oCLR;

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    rob_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .iDP_en(iDP_en), .iDP_rd_regnm(iDP_rd_regnm), .iDP_st(iDP_st),
        .iDP_br(iDP_br), .iDP_pd(iDP_pd),
        .iDP_q1_nick(iDP_q1_nick), .iDP_q2_nick(iDP_q2_nick),
        .oDP_full(oDP_full), .oDP_nick(oDP_nick),
        .oDP_q1_rdy(oDP_q1_rdy), .oDP_q2_rdy(oDP_q2_rdy),
        .oDP_q1_dt(oDP_q1_dt), .oDP_q2_dt(oDP_q2_dt),
        .oRF_nick_en(oRF_nick_en), .oRF_nick_regnm(oRF_nick_regnm), .oRF_nick(oRF_nick),
        .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt),
        .iCDB_jump(iCDB_jump), .iCDB_tgt(iCDB_tgt),
        .oRF_en(oRF_en), .oRF_rd_regnm(oRF_rd_regnm), .oRF_rd_dt(oRF_rd_dt),
        .oRF_rd_nick(oRF_rd_nick),
        .oLSB_commit(oLSB_commit), .oLSB_nick(oLSB_nick),
        .oCLR(oCLR), .oIF_pc(oIF_pc)
    );

    typedef struct {
        int                tag;
        logic [NAME_W-1:0] rd;
        logic              st;
        logic              br;
        logic              pd;
        logic              ready;
        logic              jump;
        logic [DATA_W-1:0] dt;
        logic [ADDR_W-1:0] tgt;
    } entry_t;

    entry_t            robQ[$];
    int                nextTag;
    logic              eRfEn, eLsb, eClr;
    logic [NAME_W-1:0] eRfRd;
    logic [DATA_W-1:0] eRfDt;
    logic [ADDR_W-1:0] ePc;
    int                eRfNick, eLsbNick;
    int                total = 0;
    int                bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        robQ.delete();
        nextTag  = 1;
        eRfEn    = 1'b0;
        eLsb     = 1'b0;
        eClr     = 1'b0;
        eRfRd    = '0;
        eRfDt    = '0;
        ePc      = '0;
        eRfNick  = 0;
        eLsbNick = 0;
    endtask

    // Tag lookup from the model: a live broadcast wins, then a ready entry.
    task automatic modelLookup(input logic [NICK_W-1:0] tag, output logic r, output logic [DATA_W-1:0] d);
        r = 1'b0;
        d = '0;
        if (tag != '0) begin
            if (iCDB_en && iCDB_nick == tag) begin
                r = 1'b1;
                d = iCDB_dt;
            end else begin
                foreach (robQ[i]) begin
                    if (robQ[i].tag == int'(tag) && robQ[i].ready) begin
                        r = 1'b1;
                        d = robQ[i].dt;
                    end
                end
            end
        end
    endtask

    // One clock edge of the model, using the inputs held during this cycle.
    task automatic modelStep();
        logic   alloc, fire;
        entry_t h, n;
        alloc = rdy && iDP_en && (robQ.size() < ROB_SIZE) && !eClr;
        if (!rdy) begin
            eRfEn = 1'b0;
            eLsb  = 1'b0;
            eClr  = 1'b0;
            return;
        end
        fire  = (robQ.size() > 0) && robQ[0].ready;
        eRfEn = 1'b0;
        eLsb  = 1'b0;
        eClr  = 1'b0;
        if (fire) begin
            h        = robQ[0];
            eRfEn    = !h.st && !h.br && (h.rd != '0);
            eRfRd    = h.rd;
            eRfDt    = h.dt;
            eRfNick  = h.tag;
            eLsb     = h.st;
            eLsbNick = h.tag;
            eClr     = h.br && (h.pd != h.jump);
            if (eClr) ePc = h.tgt;
        end
        if (iCDB_en && iCDB_nick != '0) begin
            foreach (robQ[i]) begin
                if (robQ[i].tag == int'(iCDB_nick)) begin
                    robQ[i].ready = 1'b1;
                    robQ[i].dt    = iCDB_dt;
                    robQ[i].jump  = iCDB_jump;
                    robQ[i].tgt   = iCDB_tgt;
                end
            end
        end
        if (eClr) begin
            robQ.delete();
            nextTag = 1;
        end else begin
            if (fire) void'(robQ.pop_front());
            if (alloc) begin
                n.tag   = nextTag;
                n.rd    = iDP_rd_regnm;
                n.st    = iDP_st;
                n.br    = iDP_br;
                n.pd    = iDP_pd;
                n.ready = 1'b0;
                n.jump  = 1'b0;
                n.dt    = '0;
                n.tgt   = '0;
                robQ.push_back(n);
                nextTag = (nextTag == ROB_SIZE) ? 1 : nextTag + 1;
            end
        end
    endtask

    // Compare every DUT output against the model, then advance the model.
    always @(negedge clk) begin
        logic              r1, r2, expAlloc;
        logic [DATA_W-1:0] d1, d2;
        if (!rst_n) modelReset();
        expAlloc = rdy && iDP_en && (robQ.size() < ROB_SIZE) && !eClr;
        checkOutput("full", 32'(oDP_full), 32'(robQ.size() == ROB_SIZE));
        checkOutput("dpNick", 32'(oDP_nick), 32'(nextTag));
        checkOutput("nickEn", 32'(oRF_nick_en), 32'(expAlloc && !iDP_st && iDP_rd_regnm != '0));
        checkOutput("rfNick", 32'(oRF_nick), 32'(nextTag));
        checkOutput("rfNickRegnm", 32'(oRF_nick_regnm), 32'(iDP_rd_regnm));
        modelLookup(iDP_q1_nick, r1, d1);
        modelLookup(iDP_q2_nick, r2, d2);
        checkOutput("q1Rdy", 32'(oDP_q1_rdy), 32'(r1));
        checkOutput("q1Dt", oDP_q1_dt, d1);
        checkOutput("q2Rdy", 32'(oDP_q2_rdy), 32'(r2));
        checkOutput("q2Dt", oDP_q2_dt, d2);
        checkOutput("rfEn", 32'(oRF_en), 32'(eRfEn));
        if (eRfEn) begin
            checkOutput("rfRd", 32'(oRF_rd_regnm), 32'(eRfRd));
            checkOutput("rfDt", oRF_rd_dt, eRfDt);
            checkOutput("rfRdNick", 32'(oRF_rd_nick), 32'(eRfNick));
        end
        checkOutput("lsbCommit", 32'(oLSB_commit), 32'(eLsb));
        if (eLsb) checkOutput("lsbNick", 32'(oLSB_nick), 32'(eLsbNick));
        checkOutput("clr", 32'(oCLR), 32'(eClr));
        if (eClr) checkOutput("ifPc", oIF_pc, ePc);
        if (rst_n) modelStep();
    end

    task automatic applyStimulus(input logic dpEn, input logic [NAME_W-1:0] rd, input logic st,
                                 input logic br, input logic pd, input logic cdbEn,
                                 input logic [NICK_W-1:0] cdbNick, input logic [DATA_W-1:0] cdbDt,
                                 input logic jump, input logic [ADDR_W-1:0] tgt,
                                 input logic [NICK_W-1:0] q1, input logic [NICK_W-1:0] q2);
        iDP_en       = dpEn;
        iDP_rd_regnm = rd;
        iDP_st       = st;
        iDP_br       = br;
        iDP_pd       = pd;
        iCDB_en      = cdbEn;
        iCDB_nick    = cdbNick;
        iCDB_dt      = cdbDt;
        iCDB_jump    = jump;
        iCDB_tgt     = tgt;
        iDP_q1_nick  = q1;
        iDP_q2_nick  = q2;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic randomCycles(input int n, input int dpPct, input int cdbPct);
        int          cands[$];
        int          kind, t;
        logic [31:0] dt, tg;
        for (int i = 0; i < n; i++) begin
            cands = {};
            foreach (robQ[k]) if (!robQ[k].ready) cands.push_back(robQ[k].tag);
            if (cands.size() > 0 && $urandom_range(99) < 85)
                t = cands[$urandom_range(cands.size() - 1)];
            else
                t = int'($urandom_range(15));
            kind = int'($urandom_range(9));
            dt   = $urandom;
            tg   = $urandom;
            rdy  = ($urandom_range(99) < 90);
            applyStimulus($urandom_range(99) < dpPct, NAME_W'($urandom_range(31)),
                          kind < 2, kind >= 2 && kind < 4, 1'($urandom_range(1)),
                          $urandom_range(99) < cdbPct, NICK_W'(t), dt,
                          1'($urandom_range(1)), tg,
                          ($urandom_range(3) == 0) ? NICK_W'(t) : NICK_W'($urandom_range(15)),
                          NICK_W'($urandom_range(15)));
            stepCycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        stepCycle();
        stepCycle();
        checkOutput("resetFull", 32'(oDP_full), 32'd0);
        checkOutput("resetNick", 32'(oDP_nick), 32'd1);
        checkOutput("resetRfEn", 32'(oRF_en), 32'd0);
        checkOutput("resetClr", 32'(oCLR), 32'd0);
        checkOutput("resetPc", oIF_pc, 32'd0);
        rst_n = 1'b1;
        stepCycle();

        // Dispatch x5, broadcast its result, see it commit a cycle later.
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("litNickEn", 32'(oRF_nick_en), 32'd1);
        checkOutput("litNick", 32'(oRF_nick), 32'd1);
        checkOutput("litNickRegnm", 32'(oRF_nick_regnm), 32'd5);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h2A, 0, 0, 0, 0);
        stepCycle();
        idle();
        #1;
        checkOutput("litNoEarlyCommit", 32'(oRF_en), 32'd0);
        stepCycle();
        #1;
        checkOutput("litRfEn", 32'(oRF_en), 32'd1);
        checkOutput("litRfRd", 32'(oRF_rd_regnm), 32'd5);
        checkOutput("litRfDt", oRF_rd_dt, 32'h2A);
        checkOutput("litRfNick", 32'(oRF_rd_nick), 32'd1);
        stepCycle();

        // Register op as tag 2, store as tag 3, lookups with forwarding.
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(1, 7, 1, 0, 0, 1, 2, 32'h11, 0, 0, 0, 0);
        #1;
        checkOutput("litStoreNoRename", 32'(oRF_nick_en), 32'd0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h7, 0, 0, 3, 2);
        #1;
        checkOutput("litQ1FwdRdy", 32'(oDP_q1_rdy), 32'd1);
        checkOutput("litQ1FwdDt", oDP_q1_dt, 32'h7);
        checkOutput("litQ2Dt", oDP_q2_dt, 32'h11);
        stepCycle();
        idle();
        stepCycle();
        #1;
        checkOutput("litLsbCommit", 32'(oLSB_commit), 32'd1);
        checkOutput("litLsbNick", 32'(oLSB_nick), 32'd3);
        checkOutput("litLsbNoRf", 32'(oRF_en), 32'd0);
        stepCycle();

        // A ready head held off by three stall cycles.
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'h55, 0, 0, 0, 0);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            checkOutput("litStallRfEn", 32'(oRF_en), 32'd0);
            checkOutput("litStallNick", 32'(oDP_nick), 32'd5);
            stepCycle();
        end
        rdy = 1'b1;
        idle();
        stepCycle();
        #1;
        checkOutput("litPostStallNick", 32'(oRF_rd_nick), 32'd4);
        stepCycle();

        // Mispredicted branch flushes and redirects.
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 1, 32'h100, 0, 0);
        stepCycle();
        idle();
        stepCycle();
        applyStimulus(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("litClr", 32'(oCLR), 32'd1);
        checkOutput("litPc", oIF_pc, 32'h100);
        checkOutput("litFlushNick", 32'(oDP_nick), 32'd1);
        checkOutput("litFlushNoAlloc", 32'(oRF_nick_en), 32'd0);
        stepCycle();
        idle();
        #1;
        checkOutput("litClrOnce", 32'(oCLR), 32'd0);
        stepCycle();

        // Fill all fifteen entries, then a sixteenth dispatch is refused.
        for (int i = 0; i < ROB_SIZE; i++) begin
            applyStimulus(1, NAME_W'(i + 1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            stepCycle();
        end
        applyStimulus(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("litFull", 32'(oDP_full), 32'd1);
        checkOutput("litFullWrapNick", 32'(oDP_nick), 32'd1);
        checkOutput("litFullNoAlloc", 32'(oRF_nick_en), 32'd0);
        stepCycle();

        // Reset with a full buffer discards everything quietly.
        rst_n = 1'b0;
        idle();
        #1;
        checkOutput("litMidResetFull", 32'(oDP_full), 32'd0);
        checkOutput("litMidResetNick", 32'(oDP_nick), 32'd1);
        checkOutput("litMidResetClr", 32'(oCLR), 32'd0);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();

        randomCycles(400, 60, 70);
        randomCycles(40, 90, 5);
        rst_n = 1'b0;
        idle();
        stepCycle();
        rst_n = 1'b1;
        randomCycles(400, 55, 75);
        idle();
        rdy = 1'b1;
        stepCycle();
        stepCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
